// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size codes, controller state type and byte-enable helper
// shared by dmem_ctrl and dmem_lane_align.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Byte lanes touched by an access; lo must already be size-aligned.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = '0;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lo;
            SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for dmem_ctrl. Places store
// data on the byte lanes and extracts/extends load data from a memory word.
// Low address bits that do not fit the access size are ignored here; whether
// such an access faults is decided by the controller.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [1:0]  eff_lo;
    logic [31:0] shifted;

    // Force the lane offset onto the natural boundary of the access size.
    always_comb begin
        eff_lo = lo;
        if (size == SIZE_HALF) begin
            eff_lo = {lo[1], 1'b0};
        end else if (size == SIZE_WORD) begin
            eff_lo = 2'b00;
        end
    end

    assign be = byte_en(size, eff_lo);

    // Replicate store data across lanes; the byte enables pick the live ones.
    always_comb begin
        wdata_lane = '0;
        case (size)
            SIZE_BYTE: wdata_lane = {4{wdata[7:0]}};
            SIZE_HALF: wdata_lane = {2{wdata[15:0]}};
            SIZE_WORD: wdata_lane = wdata;
            default:   wdata_lane = '0;
        endcase
    end

    // Shift the selected lane down to bit 0 and extend to 32 bits.
    always_comb begin
        shifted   = rword >> {eff_lo, 3'b000};
        rdata_ext = '0;
        case (size)
            SIZE_BYTE: rdata_ext = zero_ext ? {24'h000000, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: rdata_ext = zero_ext ? {16'h0000, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_WORD: rdata_ext = rword;
            default:   rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable data memory with valid/ready requests,
// configurable response latency, post-reset clear engine and a debug read port.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// fault instead of having their low address bits ignored.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 1
)(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic                     REQ_WRITE,
    input  logic [1:0]               REQ_SIZE,
    input  logic                     REQ_UNSIGNED,
    input  logic [ADDR_W-1:0]        REQ_ADDR,
    input  logic [31:0]              REQ_WDATA,
    output logic                     RSP_VALID,
    output logic [31:0]              RSP_RDATA,
    output logic                     RSP_ERR,
    output logic                     CLEAR_BUSY,
    input  logic [$clog2(DEPTH)-1:0] DBG_ADDR,
    output logic [31:0]              DBG_DATA
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // WAIT is entered with the number of further WAIT cycles still to go.
    localparam logic [1:0] WAIT_LOAD = 2'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t state, next_state;

    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  clr_cnt;
    logic [1:0]        wait_cnt;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              out_of_range;
    logic              misalign;
    logic              req_err;
    logic              accept;
    logic              clr_we;
    logic              st_we;
    logic [3:0]        be;
    logic [31:0]       wdata_lane;
    logic [31:0]       rdata_ext;

    assign word_idx     = REQ_ADDR[ADDR_W-1:2];
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign out_of_range = (word_idx >> IDX_W) != '0;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((REQ_SIZE == SIZE_HALF) && REQ_ADDR[0]) ||
                      ((REQ_SIZE == SIZE_WORD) && (REQ_ADDR[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = out_of_range || (REQ_SIZE == SIZE_ILL) || misalign;
    assign st_we   = accept && REQ_WRITE && !req_err;

    dmem_lane_align u_lane (
        .size       (REQ_SIZE),
        .lo         (REQ_ADDR[1:0]),
        .zero_ext   (REQ_UNSIGNED),
        .wdata      (REQ_WDATA),
        .rword      (mem[mem_idx]),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    // State register; reset restarts the clear sweep and drops any request in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus state-derived handshake and status outputs.
    always_comb begin
        next_state = state;
        REQ_READY  = 1'b0;
        RSP_VALID  = 1'b0;
        CLEAR_BUSY = 1'b0;
        clr_we     = 1'b0;
        accept     = 1'b0;
        case (state)
            CLEAR: begin
                CLEAR_BUSY = 1'b1;
                clr_we     = 1'b1;
                if (clr_cnt == '1) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    accept     = 1'b1;
                    next_state = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                RSP_VALID  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = CLEAR;
        endcase
    end

    // Clear sweep index and latency countdown.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clr_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            if (clr_we) begin
                clr_cnt <= clr_cnt + IDX_W'(1);
            end
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
        end
    end

    // Response is resolved at the accept edge and held until the RESP cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_err_q   <= req_err;
            rsp_rdata_q <= (REQ_WRITE || req_err) ? '0 : rdata_ext;
        end
    end

    // Array writes: zero fill during the sweep, byte-enabled stores otherwise.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (st_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[mem_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    assign RSP_RDATA = RSP_VALID ? rsp_rdata_q : '0;
    assign RSP_ERR   = RSP_VALID && rsp_err_q;
    assign DBG_DATA  = mem[DBG_ADDR];

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vector table, reset/clear sequences and randomized
// requests checked against a byte-array reference of the memory.
`timescale 1ns/1ps
module tb_dmem_ctrl;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 3;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic             CLK = 1'b0;
    logic             RESET;
    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_WRITE;
    logic [1:0]       REQ_SIZE;
    logic             REQ_UNSIGNED;
    logic [31:0]      REQ_ADDR;
    logic [31:0]      REQ_WDATA;
    logic             RSP_VALID;
    logic [31:0]      RSP_RDATA;
    logic             RSP_ERR;
    logic             CLEAR_BUSY;
    logic [IDX_W-1:0] DBG_ADDR;
    logic [31:0]      DBG_DATA;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [DEPTH*4];

    typedef struct {
        logic             w;
        logic [1:0]       sz;
        logic             zext;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [31:0]      exp_rd;
        logic             exp_er;
        logic             chk_dbg;
        logic [IDX_W-1:0] dbg_idx;
        logic [31:0]      dbg_exp;
    } vec_t;

    vec_t vecs[14];

    always #5 CLK = ~CLK;

    dmem_ctrl #(
        .DEPTH   (DEPTH),
        .ADDR_W  (32),
        .LATENCY (LAT)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_WRITE    (REQ_WRITE),
        .REQ_SIZE     (REQ_SIZE),
        .REQ_UNSIGNED (REQ_UNSIGNED),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_WDATA    (REQ_WDATA),
        .RSP_VALID    (RSP_VALID),
        .RSP_RDATA    (RSP_RDATA),
        .RSP_ERR      (RSP_ERR),
        .CLEAR_BUSY   (CLEAR_BUSY),
        .DBG_ADDR     (DBG_ADDR),
        .DBG_DATA     (DBG_DATA)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, access rules applied directly.
    task automatic ref_access(input logic w, input logic [1:0] sz, input logic zext,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
        int unsigned nb;
        int unsigned base;
        logic [1:0]  lo;
        logic [31:0] v;
        lo = a[1:0];
        rd = '0;
        er = (sz == 2'b11) || ((a >> 2) >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00)) er = 1'b1;
`else
        if (sz == 2'b01) lo[0] = 1'b0;
        if (sz == 2'b10) lo = 2'b00;
`endif
        if (!er) begin
            nb   = 1 << sz;
            base = (a >> 2) * 4 + 32'(lo);
            if (w) begin
                for (int unsigned i = 0; i < nb; i++) ref_mem[base + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[base + i];
                if (!zext && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8*nb));
                rd = v;
            end
        end
    endtask

    function automatic logic [31:0] ref_word(input int unsigned i);
        return {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    endfunction

    task automatic ref_clear();
        for (int unsigned i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    endtask

    // Issue one request from a negedge in IDLE; returns the response seen.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic zext,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er,
                           output int lat, output logic leak);
        for (int i = 0; i < 10 && !REQ_READY; i++) @(negedge CLK);
        REQ_VALID    = 1'b1;
        REQ_WRITE    = w;
        REQ_SIZE     = sz;
        REQ_UNSIGNED = zext;
        REQ_ADDR     = a;
        REQ_WDATA    = wd;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        rd   = '0;
        er   = 1'b0;
        lat  = 0;
        leak = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (RSP_VALID) begin
                lat = i;
                rd  = RSP_RDATA;
                er  = RSP_ERR;
                break;
            end
            if (REQ_READY) leak = 1'b1;
            @(negedge CLK);
        end
        @(negedge CLK);
    endtask

    task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic zext,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        leak;
        run_req(w, sz, zext, a, wd, rd, er, lat, leak);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " err"}, 32'(er), 32'(exp_er));
        check({tag, " latency"}, 32'(lat), LAT);
        check({tag, " ready_low_while_busy"}, 32'(leak), 32'd0);
        check({tag, " single_pulse"}, 32'(RSP_VALID), 32'd0);
        check({tag, " ready_back"}, 32'(REQ_READY), 32'd1);
    endtask

    // Count cycles from reset release until the clear sweep finishes.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < int'(DEPTH) + 20; i++) begin
            @(negedge CLK);
            n++;
            if (!CLEAR_BUSY) break;
        end
        check({tag, " clear_cycles"}, 32'(n), DEPTH);
        check({tag, " ready_after_clear"}, 32'(REQ_READY), 32'd1);
    endtask

    task automatic dbg_check(input string tag, input logic [IDX_W-1:0] idx, input logic [31:0] exp);
        DBG_ADDR = idx;
        #1;
        check(tag, DBG_DATA, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] erd;
        logic        eer;
        logic        w;
        logic [1:0]  sz;
        logic        zext;
        logic [31:0] a;
        logic [31:0] wd;
        logic        seen;
        int unsigned di;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 8'd4, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'h000000BE, 1'b0, 1'b0, 8'd0, 32'h0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0, 1'b0, 8'd0, 32'h0};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0, 1'b0, 8'd0, 32'h0};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h0000DEAD, 1'b0, 1'b0, 8'd0, 32'h0};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 32'h11,  32'h0000005A, 32'h0,        1'b0, 1'b1, 8'd4, 32'hDEAD5AEF};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        32'h0000005A, 1'b0, 1'b0, 8'd0, 32'h0};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 32'h0,        1'b1, 1'b1, 8'd0, 32'h0};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 1'b0, 8'd0, 32'h0};
        vecs[9]  = '{1'b1, 2'b11, 1'b0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1, 1'b1, 8'd4, 32'hDEAD5AEF};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 1'b0, 8'd0, 32'h0};
`else
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'hDEAD5AEF, 1'b0, 1'b0, 8'd0, 32'h0};
`endif
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h16,  32'hCAFE1234, 32'h0,        1'b0, 1'b1, 8'd5, 32'h12340000};
        vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h16,  32'h0,        32'h00001234, 1'b0, 1'b0, 8'd0, 32'h0};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        32'h0,        1'b0, 1'b0, 8'd0, 32'h0};

        RESET        = 1'b1;
        REQ_VALID    = 1'b0;
        REQ_WRITE    = 1'b0;
        REQ_SIZE     = 2'b00;
        REQ_UNSIGNED = 1'b0;
        REQ_ADDR     = '0;
        REQ_WDATA    = '0;
        DBG_ADDR     = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset clear_busy", 32'(CLEAR_BUSY), 32'd1);
        check("reset req_ready",  32'(REQ_READY),  32'd0);
        check("reset rsp_valid",  32'(RSP_VALID),  32'd0);
        check("reset rsp_rdata",  RSP_RDATA,       32'd0);
        check("reset rsp_err",    32'(RSP_ERR),    32'd0);
        RESET = 1'b0;
        wait_clear("initial");
        ref_clear();
        dbg_check("dbg idx0 cleared",   8'd0,   32'd0);
        dbg_check("dbg idx128 cleared", 8'd128, 32'd0);
        dbg_check("dbg idx255 cleared", 8'd255, 32'd0);

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            ref_access(vecs[i].w, vecs[i].sz, vecs[i].zext, vecs[i].addr, vecs[i].wdata, erd, eer);
            xact($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].zext,
                 vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_er);
            if (vecs[i].chk_dbg) dbg_check($sformatf("vec%0d dbg", i), vecs[i].dbg_idx, vecs[i].dbg_exp);
        end

        // Randomized requests against the reference
        for (int k = 0; k < 150; k++) begin
            w    = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            zext = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 32'h3F0 + $urandom_range(0, 31);
                1:       a = $urandom;
                default: a = $urandom_range(0, 63);
            endcase
            wd = $urandom;
            ref_access(w, sz, zext, a, wd, erd, eer);
            xact($sformatf("rand%0d", k), w, sz, zext, a, wd, erd, eer);
            di = $urandom_range(0, 15);
            dbg_check($sformatf("rand%0d dbg", k), IDX_W'(di), ref_word(di));
        end
        dbg_check("dbg last word", 8'd255, ref_word(255));

        // Reset while a load waits for its response
        for (int i = 0; i < 10 && !REQ_READY; i++) @(negedge CLK);
        REQ_VALID    = 1'b1;
        REQ_WRITE    = 1'b0;
        REQ_SIZE     = 2'b10;
        REQ_UNSIGNED = 1'b0;
        REQ_ADDR     = 32'h10;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        RESET     = 1'b1;
        #1;
        check("rst_wait clear_busy", 32'(CLEAR_BUSY), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (RSP_VALID) seen = 1'b1;
        end
        check("rst_wait no_response", 32'(seen), 32'd0);
        RESET = 1'b0;
        wait_clear("rst_wait");
        ref_clear();
        dbg_check("rst_wait dbg idx4 cleared", 8'd4, 32'd0);
        xact("post_reset load", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle word data memory.
- Byte-addressable with byte/half/word stores and sign/zero-extended loads.
- Valid/ready request handshake, configurable read latency, out-of-range and misalignment detection.
- Sequential post-reset clear engine; one debug read port replaces per-word output buses.
- Sits between the MEM pipeline stage and the memory array.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, ≥ 4.
- ADDR_W, 32, byte-address width on REQ_ADDR.
- LATENCY, 1, cycles from request accept to RSP_VALID; legal range 1..4.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request this cycle.
- REQ_WRITE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
- REQ_ADDR  in  ADDR_W  byte address.
- REQ_WDATA  in  32  store data, right-aligned.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  32  load result; 0 for stores and errors.
- RSP_ERR  out  1  request faulted; qualified by RSP_VALID.
- CLEAR_BUSY  out  1  clear engine running.
- DBG_ADDR  in  $clog2(DEPTH)  debug word index.
- DBG_DATA  out  32  combinational read of mem[DBG_ADDR].

Behaviour:
- Reset: RESET asserted forces FSM to CLEAR and clear counter to 0.
  - All outputs 0 except CLEAR_BUSY = 1.
  - A reset mid-request abandons that request with no response.
- CLEAR: writes 0 to mem[counter] each cycle for DEPTH cycles, then goes to IDLE.
  - REQ_READY = 0 throughout.
  - CLEAR_BUSY falls on the cycle IDLE is entered.
- IDLE: REQ_READY = 1.
  - Accept when REQ_VALID && REQ_READY.
  - Request fields are captured at the accept edge.
  - Stores update the array at the accept edge.
  - Load data is read from the array at the accept edge.
- Transitions after accept:
  - LATENCY = 1: IDLE → RESP.
  - LATENCY > 1: IDLE → WAIT, which counts LATENCY-1 cycles, then → RESP.
- RESP: RSP_VALID = 1 for exactly one cycle with RSP_RDATA/RSP_ERR, then → IDLE.
  - REQ_READY = 0 in WAIT and RESP.
  - Throughput is one request per LATENCY+1 cycles; REQ_VALID outside IDLE is ignored (held, not dropped).
- Word index = REQ_ADDR[ADDR_W-1:2]; lane = REQ_ADDR[1:0].
- Store byte: REQ_WDATA[7:0] written to lane addr[1:0]; other bytes unchanged.
- Store half: REQ_WDATA[15:0] written to bytes {addr[1],0} and {addr[1],1}.
- Store word: all four bytes written.
- Load: selected byte/half shifted to bit 0, then sign- or zero-extended per REQ_UNSIGNED. Word loads ignore REQ_UNSIGNED.
- Error conditions: word index ≥ DEPTH, or REQ_SIZE = 11. On error:
  - Stores do not modify the array.
  - RSP_RDATA = 0 and RSP_ERR = 1.
  - The response is still delivered after LATENCY cycles.
- Stores also produce a response pulse, with RSP_RDATA = 0.
- DBG_DATA is pure combinational. During CLEAR it shows the partially cleared array.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, is an error (rules as above).
- Undefined: offending low address bits are forced to 0 (half ignores bit 0, word ignores bits 1:0) and the access completes normally with RSP_ERR = 0.

Decomposition:
- Package dmem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - FSM state enum {CLEAR, IDLE, WAIT, RESP}.
  - Function returning the 4-bit byte-enable from size and addr[1:0].
- Sub-module dmem_lane_align: combinational store byte-enable/data placement and load extract/extend. This keeps the top level as FSM plus array.

Test Plan:
- Reset then idle, DEPTH = 256: CLEAR_BUSY high for 256 cycles; REQ_READY rises the next cycle; DBG_DATA = 0 for indices 0, 128, 255.
- Word store 0xDEADBEEF @0x10, then byte load unsigned @0x11 → RSP_RDATA = 0x000000BE; signed byte load @0x13 → 0xFFFFFFDE; signed half load @0x12 → 0xFFFFDEAD.
- Byte store 0x5A @0x11 over 0xDEADBEEF → DBG_DATA[4] = 0xDEAD5AEF.
- LATENCY = 3, load accepted at cycle t → RSP_VALID only at t+3; REQ_READY low for t+1..t+3; high again at t+4.
- Store to word index 256 (addr 0x400) → RSP_ERR = 1, RSP_RDATA = 0, array unchanged; REQ_SIZE = 11 → RSP_ERR = 1.
- Word load @0x12:
  - With DMEM_MISALIGN_TRAP_EN → RSP_ERR = 1, RSP_RDATA = 0.
  - Without it → returns mem[4], RSP_ERR = 0.
- RESET asserted during WAIT → no RSP_VALID pulse; CLEAR restarts.
